// File: rtl/wait_state_sram_model.sv
// rtl/wait_state_sram_model.sv - wait-state word SRAM model for the RV32ICore memory bus
//
// Purpose:
//   Single-port word SRAM with programmable wait states, two aliased
//   address windows, alignment/window fault generation, an optional
//   read-only window 0 and completed-access / fault counters.
//
// Optional feature macro: WAIT_STATE_SRAM_TRACE_EN
//   Defined   : completed writes and faults are traced with $display
//               (simulation only).
//   Undefined : no tracing; cycle behaviour is identical.
//
// Ports:
//   clk                in  1   system clock
//   rst                in  1   synchronous active-high reset
//   memoryAddress      in  32  byte address
//   memoryByteSelect   in  4   bit k selects byte at address+k
//   memoryWriteEnable  in  1   write request (wins if read is also high)
//   memoryReadEnable   in  1   read request
//   memoryDataWrite    in  32  right-justified write data
//   memoryDataRead     out 32  right-justified read data, unselected lanes 0
//   memoryBusy         out 1   access not complete this cycle
//   memoryAccessFault  out 1   access rejected this cycle
//   readCount          out 32  completed reads (wraps)
//   writeCount         out 32  completed writes (wraps)
//   faultCount         out 16  faulted accesses (saturates)

module wait_state_sram_model #(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [7:0]  WINDOW0_BASE = 8'h00,
  parameter logic [7:0]  WINDOW1_BASE = 8'h80,
  parameter bit          WINDOW0_RO   = 1'b0,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memoryAddress,
  input  logic [3:0]  memoryByteSelect,
  input  logic        memoryWriteEnable,
  input  logic        memoryReadEnable,
  input  logic [31:0] memoryDataWrite,
  output logic [31:0] memoryDataRead,
  output logic        memoryBusy,
  output logic        memoryAccessFault,
  output logic [31:0] readCount,
  output logic [31:0] writeCount,
  output logic [15:0] faultCount
);

  localparam int unsigned DEPTH      = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0]  WAIT_LIMIT = WAIT_STATES[3:0];

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  // Storage
  logic [31:0] mem_q [DEPTH];

  // Wait FSM and the access it is counting for
  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic        wr_q, wr_d;

  logic [31:0] read_cnt_q, write_cnt_q;
  logic [15:0] fault_cnt_q;

  // Request decode
  logic                  request;
  logic                  is_write;
  logic                  win0_hit;
  logic                  win1_hit;
  logic [1:0]            sel_top;
  logic [2:0]            last_lane;
  logic                  fault;
  logic                  accept;
  logic                  restart;
  logic [3:0]            eff_cnt;
  logic                  complete;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rd_word;
  logic [31:0]           rd_data;
  logic                  unused_addr_bits;

  function automatic logic [1:0] sel_msb(input logic [3:0] s);
    if (s[3])      return 2'd3;
    else if (s[2]) return 2'd2;
    else if (s[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign request  = memoryWriteEnable | memoryReadEnable;
  assign is_write = memoryWriteEnable;
  assign win0_hit = (memoryAddress[31:24] == WINDOW0_BASE);
  assign win1_hit = (memoryAddress[31:24] == WINDOW1_BASE);
  assign sel_top  = sel_msb(memoryByteSelect);
  // Highest byte touched, relative to the word base; 4 or more means the
  // access spills into the next word.
  assign last_lane = {1'b0, memoryAddress[1:0]} + {1'b0, sel_top};
  assign word_idx  = memoryAddress[ADDR_WIDTH-1:2];
  // Address bits above the window decode are ignored (storage aliases).
  assign unused_addr_bits = ^memoryAddress;

  always_comb begin
    fault = 1'b0;
    if (!(win0_hit || win1_hit))                       fault = 1'b1;
    if (memoryByteSelect == 4'b0000)                   fault = 1'b1;
    if (last_lane > 3'd3)                              fault = 1'b1;
    if (WINDOW0_RO && is_write && win0_hit && !win1_hit) fault = 1'b1;
  end

  assign accept = request && !fault;

  // A pending access that disappears or changes shape is abandoned; the
  // request now present (if any) starts counting from zero this cycle.
  assign restart = (state_q == S_WAIT) &&
                   (!request || (memoryAddress != addr_q) ||
                    (memoryByteSelect != sel_q) || (is_write != wr_q));
  assign eff_cnt  = restart ? 4'd0 : wait_cnt_q;
  assign complete = accept && (eff_cnt == WAIT_LIMIT);

  always_comb begin
    state_d    = S_IDLE;
    wait_cnt_d = 4'd0;
    addr_d     = memoryAddress;
    sel_d      = memoryByteSelect;
    wr_d       = is_write;
    if (accept && !complete) begin
      state_d    = S_WAIT;
      wait_cnt_d = eff_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= 32'd0;
      sel_q      <= 4'd0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
    end
  end

  // Read path: lane k of the bus takes byte (address[1:0]+k) of the word.
  assign rd_word = mem_q[word_idx];

  always_comb begin
    rd_data = 32'd0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] lane;
      lane = memoryAddress[1:0] + k[1:0];
      if (memoryByteSelect[k]) rd_data[8*k +: 8] = rd_word[{lane, 3'b000} +: 8];
    end
  end

  // Write path: committed only on the completing edge.
  always_ff @(posedge clk) begin
    if (!rst && complete && is_write) begin
      for (int k = 0; k < 4; k++) begin
        if (memoryByteSelect[k]) begin
          mem_q[word_idx][{memoryAddress[1:0] + k[1:0], 3'b000} +: 8] <= memoryDataWrite[8*k +: 8];
        end
      end
    end
  end

  // Counters
  always_ff @(posedge clk) begin
    if (rst) begin
      read_cnt_q  <= 32'd0;
      write_cnt_q <= 32'd0;
      fault_cnt_q <= 16'd0;
    end else begin
      if (complete && is_write)  write_cnt_q <= write_cnt_q + 32'd1;
      if (complete && !is_write) read_cnt_q  <= read_cnt_q + 32'd1;
      if (request && fault && (fault_cnt_q != 16'hFFFF)) fault_cnt_q <= fault_cnt_q + 16'd1;
    end
  end

`ifdef WAIT_STATE_SRAM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && complete && is_write)
      $display("Write of 0x%08h to 0x%08h", memoryDataWrite, memoryAddress);
    if (!rst && request && fault)
      $display("Fault at 0x%08h", memoryAddress);
  end
`else
`endif

  // Outputs are held quiet throughout reset.
  assign memoryBusy        = !rst && accept && !complete;
  assign memoryAccessFault = !rst && request && fault;
  assign memoryDataRead    = (!rst && complete && !is_write) ? rd_data : 32'd0;
  assign readCount         = read_cnt_q;
  assign writeCount        = write_cnt_q;
  assign faultCount        = fault_cnt_q;

endmodule

// File: tb/tb_wait_state_sram_model.sv
// tb/tb_wait_state_sram_model.sv - directed bench for wait_state_sram_model
module tb_wait_state_sram_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WS=0, 1: WS=3, 2: WS=1, 3: WS=0 with read-only window 0
  logic        rst_a [4];
  logic        we    [4];
  logic        re    [4];
  logic [31:0] ad    [4];
  logic [3:0]  bs    [4];
  logic [31:0] wd    [4];
  logic [31:0] rd    [4];
  logic        bz    [4];
  logic        ft    [4];
  logic [31:0] rc    [4];
  logic [31:0] wc    [4];
  logic [15:0] fc    [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    wait_state_sram_model #(
      .ADDR_WIDTH  (12),
      .WAIT_STATES ((g == 1) ? 3 : (g == 2) ? 1 : 0),
      .WINDOW0_BASE(8'h00),
      .WINDOW1_BASE(8'h80),
      .WINDOW0_RO  ((g == 3) ? 1'b1 : 1'b0),
      .INIT_FILE   ("")
    ) u_dut (
      .clk              (clk),
      .rst              (rst_a[g]),
      .memoryAddress    (ad[g]),
      .memoryByteSelect (bs[g]),
      .memoryWriteEnable(we[g]),
      .memoryReadEnable (re[g]),
      .memoryDataWrite  (wd[g]),
      .memoryDataRead   (rd[g]),
      .memoryBusy       (bz[g]),
      .memoryAccessFault(ft[g]),
      .readCount        (rc[g]),
      .writeCount       (wc[g]),
      .faultCount       (fc[g])
    );
  end

  typedef struct packed {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        busy;
    logic        fault;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [16];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply(input int d, input logic w, input logic r, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] dat);
    we[d] = w; re[d] = r; ad[d] = a; bs[d] = s; wd[d] = dat;
    #1;
  endtask

  task automatic idle(input int d);
    apply(d, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold one request for n busy cycles plus the completing cycle.
  task automatic hold_seq(input int d, input logic w, input logic r, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] dat, input int n,
                          input logic [31:0] exp_data, input string tag);
    for (int c = 0; c <= n; c++) begin
      apply(d, w, r, a, s, dat);
      chk($sformatf("%s busy c%0d", tag, c), {31'd0, bz[d]}, {31'd0, (c < n)});
      if (c == n) chk($sformatf("%s data", tag), rd[d], exp_data);
      tick();
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst_a[d] = 1'b1;
      we[d] = 1'b0; re[d] = 1'b0; ad[d] = 32'd0; bs[d] = 4'h0; wd[d] = 32'd0;
    end

    tbl[0]  = '{1'b1, 1'b0, 32'h00000100, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h00000103, 4'h1, 32'h000000AA, 1'b0, 1'b0, 32'h00000000};
    tbl[3]  = '{1'b0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'hAAADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 32'h00000103, 4'h3, 32'h0000BBAA, 1'b0, 1'b1, 32'h00000000};
    tbl[5]  = '{1'b0, 1'b1, 32'h40000000, 4'hF, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
    tbl[6]  = '{1'b0, 1'b1, 32'h80000100, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'hAAADBEEF};
    tbl[7]  = '{1'b0, 1'b1, 32'h00000102, 4'h3, 32'h00000000, 1'b0, 1'b0, 32'h0000AAAD};
    tbl[8]  = '{1'b0, 1'b1, 32'h00000101, 4'h4, 32'h00000000, 1'b0, 1'b0, 32'h00AA0000};
    tbl[9]  = '{1'b0, 1'b1, 32'h00000100, 4'h0, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
    tbl[10] = '{1'b0, 1'b0, 32'h00000100, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    tbl[11] = '{1'b1, 1'b1, 32'h80000200, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h00000000};
    tbl[12] = '{1'b0, 1'b1, 32'h00000200, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'h11223344};
    tbl[13] = '{1'b0, 1'b1, 32'h00000103, 4'h1, 32'h00000000, 1'b0, 1'b0, 32'h000000AA};
    tbl[14] = '{1'b1, 1'b0, 32'h00000101, 4'h6, 32'h00CCDD00, 1'b0, 1'b0, 32'h00000000};
    tbl[15] = '{1'b0, 1'b1, 32'h00000100, 4'hF, 32'h00000000, 1'b0, 1'b0, 32'hCCDDBEEF};

    // Reset: outputs quiet even with a faulting request present
    @(negedge clk);
    apply(0, 1'b0, 1'b1, 32'h40000000, 4'hF, 32'd0);
    chk("rst fault", {31'd0, ft[0]}, 32'd0);
    chk("rst busy", {31'd0, bz[0]}, 32'd0);
    chk("rst data", rd[0], 32'd0);
    tick();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst rc%0d", d), rc[d], 32'd0);
      chk($sformatf("rst wc%0d", d), wc[d], 32'd0);
      chk($sformatf("rst fc%0d", d), {16'd0, fc[d]}, 32'd0);
      rst_a[d] = 1'b0;
      idle(d);
    end
    tick();

    // Single-cycle instance, table driven
    for (int i = 0; i < 16; i++) begin
      apply(0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].sel, tbl[i].wdata);
      chk($sformatf("t%0d busy", i), {31'd0, bz[0]}, {31'd0, tbl[i].busy});
      chk($sformatf("t%0d fault", i), {31'd0, ft[0]}, {31'd0, tbl[i].fault});
      chk($sformatf("t%0d data", i), rd[0], tbl[i].data);
      tick();
    end
    idle(0);
    chk("ws0 writeCount", wc[0], 32'd4);
    chk("ws0 readCount", rc[0], 32'd8);
    chk("ws0 faultCount", {16'd0, fc[0]}, 32'd3);

    // Read-only window 0
    apply(3, 1'b1, 1'b0, 32'h80000000, 4'hF, 32'hCAFEF00D);
    chk("ro w1 write fault", {31'd0, ft[3]}, 32'd0);
    tick();
    apply(3, 1'b1, 1'b0, 32'h00000000, 4'hF, 32'h12345678);
    chk("ro w0 write fault", {31'd0, ft[3]}, 32'd1);
    tick();
    apply(3, 1'b0, 1'b1, 32'h00000000, 4'hF, 32'd0);
    chk("ro w0 read fault", {31'd0, ft[3]}, 32'd0);
    chk("ro storage kept", rd[3], 32'hCAFEF00D);
    tick();
    idle(3);
    chk("ro faultCount", {16'd0, fc[3]}, 32'd1);
    chk("ro writeCount", wc[3], 32'd1);

    // Three wait states
    hold_seq(1, 1'b1, 1'b0, 32'h00000100, 4'hF, 32'hDEADBEEF, 3, 32'd0, "ws3 wr");
    hold_seq(1, 1'b0, 1'b1, 32'h80000100, 4'hF, 32'd0, 3, 32'hDEADBEEF, "ws3 rd alias");
    idle(1);
    chk("ws3 writeCount", wc[1], 32'd1);
    chk("ws3 readCount", rc[1], 32'd1);
    // byteSelect change mid-wait restarts the count
    for (int c = 0; c < 2; c++) begin
      apply(1, 1'b0, 1'b1, 32'h00000100, 4'hF, 32'd0);
      tick();
    end
    hold_seq(1, 1'b0, 1'b1, 32'h00000100, 4'h1, 32'd0, 3, 32'h000000EF, "ws3 restart");
    idle(1);
    chk("ws3 restart readCount", rc[1], 32'd2);
    // Dropped write, then reset during the retry
    for (int c = 0; c < 2; c++) begin
      apply(1, 1'b1, 1'b0, 32'h00000100, 4'hF, 32'h55555555);
      chk($sformatf("ws3 abort busy c%0d", c), {31'd0, bz[1]}, 32'd1);
      tick();
    end
    idle(1);
    chk("ws3 drop busy", {31'd0, bz[1]}, 32'd0);
    tick();
    for (int c = 0; c < 2; c++) begin
      apply(1, 1'b1, 1'b0, 32'h00000100, 4'hF, 32'h55555555);
      tick();
    end
    rst_a[1] = 1'b1;
    apply(1, 1'b1, 1'b0, 32'h00000100, 4'hF, 32'h55555555);
    chk("ws3 rst busy", {31'd0, bz[1]}, 32'd0);
    tick();
    rst_a[1] = 1'b0;
    idle(1);
    tick();
    chk("ws3 abort writeCount", wc[1], 32'd0);
    hold_seq(1, 1'b0, 1'b1, 32'h00000100, 4'hF, 32'd0, 3, 32'hDEADBEEF, "ws3 unchanged");
    idle(1);
    chk("ws3 final readCount", rc[1], 32'd1);

    // One wait state, back-to-back reads
    hold_seq(2, 1'b1, 1'b0, 32'h00000100, 4'hF, 32'hDEADBEEF, 1, 32'd0, "ws1 wr");
    for (int a = 0; a < 3; a++)
      hold_seq(2, 1'b0, 1'b1, 32'h00000100, 4'hF, 32'd0, 1, 32'hDEADBEEF, $sformatf("ws1 b2b%0d", a));
    idle(2);
    chk("ws1 readCount", rc[2], 32'd3);
    chk("ws1 writeCount", wc[2], 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
